// File: rtl/viterbi_pkg.sv
// viterbi_pkg: constants and types shared by the K=4 convolutional encoder and the Viterbi decoder.
package viterbi_pkg;
  localparam int K = 4;
  localparam int NUM_STATES = 8;
  localparam logic [K-1:0] G0_DEF = 4'b1101;
  localparam logic [K-1:0] G1_DEF = 4'b1111;
  typedef logic [1:0] sym_t;
  typedef logic [2:0] state_t;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_fsm_t;
endpackage

// File: rtl/conv_enc_symbol.sv
// conv_enc_symbol: one trellis step -- code symbol {c0,c1} and next state for bit b leaving state s.
module conv_enc_symbol
  import viterbi_pkg::*;
(
  input  logic         b_i,
  input  state_t       s_i,
  input  logic [K-1:0] g0_i,
  input  logic [K-1:0] g1_i,
  output sym_t         sym_o,
  output state_t       next_s_o
);
  logic [K-1:0] w;
  assign w = {b_i, s_i};
  assign sym_o = {^(w & g0_i), ^(w & g1_i)};
  assign next_s_o = {b_i, s_i[2:1]};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=4 framed convolutional encoder with 3-bit zero tail per frame.
// Define CONV_ENC_ERR_INJ_EN to add the err_mask input that corrupts emitted symbols.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0        = G0_DEF,
  parameter logic [K-1:0] G1        = G1_DEF,
  parameter int           MAX_FRAME = 64,
  parameter int           CNT_W     = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
`ifdef CONV_ENC_ERR_INJ_EN
  input  logic [1:0] err_mask,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output sym_t       out_sym,
  output logic       out_tail,
  output logic       out_last,
  output logic       frame_err
);
  enc_fsm_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] tcnt_q, tcnt_d;
  state_t s_q, s_d, s_nxt;
  sym_t sym_q, sym_d, sym_c, mask;
  logic valid_q, valid_d, tail_q, tail_d, last_q, last_d, err_q, err_d;
  logic adv, in_tail, acc, tail_go, tail_end, hit, load;

  assign adv      = !valid_q || out_ready;
  assign in_tail  = state_q == TAIL;
  assign in_ready = adv && !in_tail;
  assign acc      = in_valid && in_ready;
  assign tail_go  = in_tail && adv;
  assign tail_end = tail_go && tcnt_q == 2'd2;
  assign load     = acc || tail_go;
  assign cnt_inc  = cnt_q + 1'b1;
  assign hit      = cnt_inc == CNT_W'(MAX_FRAME);
`ifdef CONV_ENC_ERR_INJ_EN
  assign mask = err_mask;
`else
  assign mask = '0;
`endif

  // Tail beats shift zeros so the trellis always terminates in state 0.
  conv_enc_symbol u_sym (
    .b_i      (in_bit && !in_tail),
    .s_i      (s_q),
    .g0_i     (G0),
    .g1_i     (G1),
    .sym_o    (sym_c),
    .next_s_o (s_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      sym_q   <= '0;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      sym_q   <= sym_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = acc ? ((in_last || hit) ? TAIL : DATA) : tail_end ? IDLE : state_q;
    cnt_d   = acc ? cnt_inc : tail_end ? '0 : cnt_q;
    tcnt_d  = tail_end ? 2'd0 : tail_go ? tcnt_q + 1'b1 : tcnt_q;
    err_d   = err_q || (acc && hit && !in_last);
  end

  // The output register and trellis state move together, only on a load.
  always_comb begin
    valid_d = adv ? load : valid_q;
    sym_d   = load ? sym_c ^ mask : sym_q;
    tail_d  = load ? in_tail : tail_q;
    last_d  = load ? tail_end : last_q;
    s_d     = load ? s_nxt : s_q;
  end

  assign out_valid = valid_q;
  assign out_sym   = sym_q;
  assign out_tail  = tail_q;
  assign out_last  = last_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed vector table, multi-cycle corner cases and a randomized scoreboard run.
module tb_conv_encoder;
  typedef struct packed {logic [1:0] sym; logic tail; logic last; logic err;} beat_t;
  typedef struct {int n; logic [7:0] bits; int ns; logic [15:0] syms; logic [7:0] tails; logic [7:0] lasts;} vec_t;
  localparam logic [3:0] TG0 = 4'b1101;
  localparam logic [3:0] TG1 = 4'b1111;

  logic clock = 0, reset = 0, in_valid = 0, in_bit = 0, in_last = 0, out_ready = 1;
  logic in_ready, out_valid, out_tail, out_last, frame_err;
  logic [1:0] out_sym;
`ifdef CONV_ENC_ERR_INJ_EN
  logic [1:0] err_mask = '0;
`endif
  int errors = 0, checks = 0, rmode = 0, tail_ns = 0, b2b_hits = 0;
  bit tail_chk = 0, p_stall = 0, p_b2b = 0, acc_flag = 0, exp_err = 0;
  logic [4:0] p_out = '0;
  bit hist[$];
  int fcnt = 0;
  beat_t expq[$], cap[$];
  vec_t vecs[4];

  conv_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
`ifdef CONV_ENC_ERR_INJ_EN
    .err_mask  (err_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_tail  (out_tail),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Convolution of the frame's bit history (newest last) with the generators.
  function automatic logic [1:0] conv();
    logic [1:0] c = '0;
    int n = hist.size() - 1;
    for (int k = 0; k < 4; k++)
      if (n - k >= 0 && hist[n-k]) begin
        c[1] ^= TG0[3-k];
        c[0] ^= TG1[3-k];
      end
    return c;
  endfunction

  task automatic model_accept(input logic b, input logic l, input logic [1:0] m);
    hist.push_back(b);
    fcnt++;
    if (fcnt == 64 && !l) exp_err = 1;
    expq.push_back('{conv() ^ m, 1'b0, 1'b0, exp_err});
    if (l || fcnt == 64) begin
      for (int i = 0; i < 3; i++) begin
        hist.push_back(1'b0);
        expq.push_back('{conv(), 1'b1, i == 2, exp_err});
      end
      hist.delete();
      fcnt = 0;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    expq.delete();
    fcnt = 0;
    exp_err = 0;
    p_stall = 0;
    p_b2b = 0;
  endtask

  task automatic tick();
    beat_t got, want;
    logic [1:0] m;
    @(negedge clock);
    if (reset) begin
      got = '{out_sym, out_tail, out_last, frame_err};
      if (p_stall) chk("stall_hold", {out_valid, out_sym, out_tail, out_last}, p_out);
      if (p_b2b) begin
        b2b_hits++;
        chk("b2b_no_gap", {out_valid, out_tail}, 2'b10);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (tail_chk && cap.size() < tail_ns - 1) chk("tail_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        cap.push_back(got);
        if (expq.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          want = expq.pop_front();
          chk("sb_beat", got, want);
        end
      end
      p_stall = out_valid && !out_ready;
      p_out = {out_valid, out_sym, out_tail, out_last};
      p_b2b = out_valid && out_ready && out_last && in_valid && in_ready;
      m = '0;
`ifdef CONV_ENC_ERR_INJ_EN
      m = err_mask;
`endif
      if (in_valid && in_ready) begin
        model_accept(in_bit, in_last, m);
        acc_flag = 1;
      end
    end
    @(posedge clock);
    #1;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic b, input logic l);
    int t = 0;
    in_valid = 1;
    in_bit = b;
    in_last = l;
    acc_flag = 0;
    while (!acc_flag && t < 200) begin
      tick();
      t++;
    end
    if (!acc_flag) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain(input int want);
    int t = 0;
    while (cap.size() < want && t < 300) begin
      tick();
      t++;
    end
    if (cap.size() < want) chk("drain_timeout", cap.size(), want);
  endtask

  initial begin
    int t, len;
    vecs[0] = '{4, 8'h0D, 7, 16'b00_11_10_10_11_10_11_11, 8'b0111_0000, 8'b0100_0000};
    vecs[1] = '{1, 8'h00, 4, 16'h0000, 8'b0000_1110, 8'b0000_1000};
    vecs[2] = '{1, 8'h01, 4, 16'b0000_0000_11_01_11_11, 8'b0000_1110, 8'b0000_1000};
    vecs[3] = '{2, 8'h02, 5, 16'b000000_11_01_11_11_00, 8'b0001_1100, 8'b0001_0000};
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sym", out_sym, 0);
    chk("rst_tail_last", {out_tail, out_last}, 0);
    chk("rst_frame_err", frame_err, 0);
    tick();
    tick();
    reset = 1;
    tick();

    // Directed table, first with out_ready held high, then toggling.
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 4; v++) begin
        rmode = r;
        cap.delete();
        for (int i = 0; i < vecs[v].n; i++) send(vecs[v].bits[i], i == vecs[v].n - 1);
        tail_ns = vecs[v].ns;
        tail_chk = 1;
        drain(vecs[v].ns);
        tail_chk = 0;
        for (int i = 0; i < vecs[v].ns && i < cap.size(); i++) begin
          chk($sformatf("vec%0d_r%0d_sym%0d", v, r, i), cap[i].sym, vecs[v].syms[2*i +: 2]);
          chk($sformatf("vec%0d_r%0d_flags%0d", v, r, i), {cap[i].tail, cap[i].last},
              {vecs[v].tails[i], vecs[v].lasts[i]});
        end
        chk("vec_frame_err", frame_err, 0);
      end

    // Back-to-back frames with in_valid held high.
    rmode = 0;
    cap.delete();
    b2b_hits = 0;
    send(1, 0); send(0, 1); send(1, 0); send(1, 1);
    drain(10);
    chk("b2b_seen", b2b_hits > 0, 1);
    chk("b2b_second_first", {cap[5].sym, cap[5].tail}, {2'b11, 1'b0});

    // MAX_FRAME without in_last forces a tail and sets the sticky error.
    cap.delete();
    for (int i = 0; i < 64; i++) begin
      send(1'($urandom_range(0, 1)), 1'b0);
      if (i == 62) chk("err_before_64", frame_err, 0);
    end
    chk("err_after_64", frame_err, 1);
    tail_ns = 67;
    tail_chk = 1;
    drain(67);
    tail_chk = 0;
    chk("max_tail_flags", {cap[63].tail, cap[64].tail, cap[66].last}, 3'b011);
    send(1, 1);
    drain(71);
    chk("new_frame_sym", cap[67].sym, 2'b11);
    chk("err_sticky", frame_err, 1);

    // Randomized frames, gaps and back-pressure.
    rmode = 2;
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(1'($urandom_range(0, 1)), i == len - 1);
      end
    end
    t = 0;
    while (expq.size() > 0 && t < 500) begin
      tick();
      t++;
    end
    chk("sb_empty", expq.size(), 0);

    // Asynchronous reset in the middle of a tail.
    rmode = 0;
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    tick();
    #2;
    reset = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sym", out_sym, 0);
    chk("async_rst_flags", {out_tail, out_last, frame_err}, 0);
    model_reset();
    tick();
    reset = 1;
    cap.delete();
`ifdef CONV_ENC_ERR_INJ_EN
    err_mask = 2'b01;
    send(1, 1);
    err_mask = 2'b00;
    drain(4);
    chk("post_rst_first_masked", cap[0].sym, 2'b10);
`else
    send(1, 1);
    drain(4);
    chk("post_rst_first", cap[0].sym, 2'b11);
`endif
    chk("post_rst_last", cap[3].last, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
